// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the alu_mdu slice.
//   alu_op_e      : 4-bit operation select seen on the ALUOp bus
//   MDU_*_CYCLES  : default busy lengths for multiply and divide
//   is_mdu_op()   : true for the opcodes handled by the multiply/divide unit
package alu_mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_SRA   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MULT  = 4'd10,
    ALU_MULTU = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_MTHI  = 4'd14,
    ALU_MTLO  = 4'd15
  } alu_op_e;

  localparam int MDU_MUL_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;

  function automatic logic is_mdu_op(input alu_op_e op);
    return op >= ALU_MULT;
  endfunction

endpackage

// File: rtl/alu_mdu_mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit with HI/LO registers.
//   clk_i, reset_i : clock, synchronous active-high reset
//   a_i, b_i       : operands, latched on accept
//   op_i           : operation select (only MDU opcodes act)
//   start_i        : qualifies op_i this cycle; ignored while busy
//   busy_o         : operation in flight
//   hi_o, lo_o     : HI/LO registers
module mdu_core
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Result datapath works on the latched operands only.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   divisor, mag_a, mag_b, mag_q, mag_r, q_s, r_s, q_u, r_u;

  always_comb begin
    // Low 2W bits of a product of sign-extended operands is the signed product.
    prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Divide-by-zero never commits; keep the divider free of X.
    divisor = (b_q == '0) ? WIDTH'(1) : b_q;
    // Signed divide via magnitudes; most-negative / -1 falls out as lo=A, hi=0.
    mag_a   = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b   = divisor[WIDTH-1] ? -divisor : divisor;
    mag_q   = mag_a / mag_b;
    mag_r   = mag_a % mag_b;
    q_s     = (a_q[WIDTH-1] ^ divisor[WIDTH-1]) ? -mag_q : mag_q;
    r_s     = a_q[WIDTH-1] ? -mag_r : mag_r;
    q_u     = a_q / divisor;
    r_u     = a_q % divisor;
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        case (op_q)
          ALU_MULT:  {hi_d, lo_d} = prod_s;
          ALU_MULTU: {hi_d, lo_d} = prod_u;
          ALU_DIV: if (b_q != '0) begin
            lo_d = q_s;
            hi_d = r_s;
          end
          ALU_DIVU: if (b_q != '0) begin
            lo_d = q_u;
            hi_d = r_u;
          end
          default: ;
        endcase
      end
    end else if (start_i) begin
      case (alu_op_e'(op_i))
        ALU_MULT, ALU_MULTU: begin
          op_d   = alu_op_e'(op_i);
          a_d    = a_i;
          b_d    = b_i;
          cnt_d  = CW'(MUL_CYCLES);
          busy_d = 1'b1;
        end
        ALU_DIV, ALU_DIVU: begin
          op_d   = alu_op_e'(op_i);
          a_d    = a_i;
          b_d    = b_i;
          cnt_d  = CW'(DIV_CYCLES);
          busy_d = 1'b1;
        end
        ALU_MTHI: hi_d = a_i;
        ALU_MTLO: lo_d = a_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= ALU_ADD;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy_o = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with combinational ops and a multi-cycle MDU.
//   clk_i, reset_i : clock, synchronous active-high reset
//   a_i, b_i       : operands (shift amount is low log2(WIDTH) bits of b_i)
//   alu_op_i       : operation select
//   start_i        : qualifies MDU ops this cycle
//   c_o            : combinational result, 0 for MDU opcodes
//   busy_o         : MDU operation in flight
//   hi_o, lo_o     : HI/LO registers
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_op_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] c_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    c_o = '0;
    case (alu_op_e'(alu_op_i))
      ALU_ADD:  c_o = a_i + b_i;
      ALU_SUB:  c_o = a_i - b_i;
      ALU_AND:  c_o = a_i & b_i;
      ALU_OR:   c_o = a_i | b_i;
      ALU_SRL:  c_o = a_i >> shamt;
      ALU_SRA:  c_o = $signed(a_i) >>> shamt;
      ALU_SLL:  c_o = a_i << shamt;
      ALU_XOR:  c_o = a_i ^ b_i;
      ALU_SLT:  c_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: c_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default:  c_o = '0;
    endcase
  end

  mdu_core #(
    .WIDTH     (WIDTH),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_mdu (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .op_i   (alu_op_i),
    .start_i(start_i),
    .busy_o (busy_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, c, hi, lo;
  logic [3:0]  alu_op;
  logic        start, busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  alu_mdu dut (
    .clk_i   (clk),
    .reset_i (reset),
    .a_i     (a),
    .b_i     (b),
    .alu_op_i(alu_op),
    .start_i (start),
    .c_o     (c),
    .busy_o  (busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] ai, input logic [31:0] bi);
    longint sa = $signed(ai);
    longint sb = $signed(bi);
    longint ua = ai;
    longint ub = bi;
    longint p  = longint'(1) << bi[4:0];
    longint r  = 0;
    case (op)
      0: r = ua + ub;
      1: r = ua - ub;
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ua / p;
      5: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      6: r = ua * p;
      7: r = ai ^ bi;
      8: r = (sa < sb) ? 1 : 0;
      9: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic mdu_model(input int op, input logic [31:0] ai, input logic [31:0] bi,
                           input logic [31:0] hi_in, input logic [31:0] lo_in,
                           output logic [31:0] hi_out, output logic [31:0] lo_out,
                           output int cyc);
    longint sa = $signed(ai);
    longint sb = $signed(bi);
    longint unsigned ua = ai;
    longint unsigned ub = bi;
    longint ps, qs, rs;
    longint unsigned pu;
    hi_out = hi_in;
    lo_out = lo_in;
    cyc = 0;
    case (op)
      10: begin ps = sa * sb; hi_out = ps[63:32]; lo_out = ps[31:0]; cyc = 5; end
      11: begin pu = ua * ub; hi_out = pu[63:32]; lo_out = pu[31:0]; cyc = 5; end
      12: begin
        cyc = 10;
        if (bi != 0) begin
          qs = sa / sb; rs = sa % sb;
          lo_out = qs[31:0]; hi_out = rs[31:0];
        end
      end
      13: begin
        cyc = 10;
        if (bi != 0) begin lo_out = 32'(ua / ub); hi_out = 32'(ua % ub); end
      end
      14: hi_out = ai;
      15: lo_out = ai;
      default: ;
    endcase
  endtask

  // Issues one MDU op, counts busy cycles while scrambling the inputs,
  // optionally injects a mthi in the 2nd busy cycle, then checks HI/LO.
  task automatic run_mdu(input string nm, input logic [3:0] op, input logic [31:0] ai,
                         input logic [31:0] bi, input bit inject);
    logic [31:0] ehi, elo;
    int ecyc, n;
    bit held;
    mdu_model(int'(op), ai, bi, m_hi, m_lo, ehi, elo, ecyc);
    alu_op = op; a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; held = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      if (inject && n == 2) begin
        start = 1'b1; alu_op = 4'd14; a = 32'd9;
      end else begin
        start = 1'b0; alu_op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_cycles"}, 32'(n), 32'(ecyc));
    if (ecyc > 0) chk({nm, "_hold"}, 32'(held), 32'd1);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    vec_t vecs[$];
    int n;
    logic [3:0] rop;
    reset = 1'b1; start = 1'b0; alu_op = 4'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    vecs.push_back('{4'd0, 32'd5, 32'd7, 32'd12});
    vecs.push_back('{4'd1, 32'd0, 32'd1, 32'hFFFFFFFF});
    vecs.push_back('{4'd5, 32'h80000000, 32'h24, 32'hF8000000});
    vecs.push_back('{4'd4, 32'h80000000, 32'h24, 32'h08000000});
    vecs.push_back('{4'd6, 32'h80000000, 32'h24, 32'h0});
    vecs.push_back('{4'd8, 32'hFFFFFFFF, 32'd1, 32'd1});
    vecs.push_back('{4'd9, 32'hFFFFFFFF, 32'd1, 32'd0});
    vecs.push_back('{4'd2, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000});
    vecs.push_back('{4'd3, 32'hF0000000, 32'h0000000F, 32'hF000000F});
    vecs.push_back('{4'd7, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00});
    vecs.push_back('{4'd0, 32'hFFFFFFFF, 32'd1, 32'd0});
    vecs.push_back('{4'd5, 32'h7FFFFFFF, 32'd31, 32'd0});
    vecs.push_back('{4'd6, 32'd1, 32'd63, 32'h80000000});
    vecs.push_back('{4'd10, 32'd3, 32'd4, 32'd0});
    vecs.push_back('{4'd15, 32'd3, 32'd4, 32'd0});
    foreach (vecs[i]) begin
      alu_op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_op%0d", i, vecs[i].op), c, vecs[i].c);
    end

    for (int i = 0; i < 200; i++) begin
      alu_op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
      if (i % 8 == 0) a = 32'h80000000;
      #1;
      chk($sformatf("rnd_comb_op%0d", alu_op), c, ref_alu(int'(alu_op), a, b));
    end

    @(posedge clk); #1;
    // start with a combinational op must not touch the MDU
    alu_op = 4'd0; start = 1'b1; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_alu_busy", 32'(busy), 32'd0);
    chk("start_alu_hi", hi, m_hi);

    run_mdu("mult", 4'd10, 32'hFFFFFFFD, 32'd4, 1'b0);
    run_mdu("multu", 4'd11, 32'hFFFFFFFD, 32'd4, 1'b0);
    run_mdu("div", 4'd12, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_mdu("divu_zero", 4'd13, 32'd7, 32'd0, 1'b0);
    run_mdu("div_ovf", 4'd12, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_mdu("div_zero", 4'd12, 32'h1234, 32'd0, 1'b0);
    run_mdu("mult_inj", 4'd10, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    run_mdu("mthi", 4'd14, 32'd9, 32'd0, 1'b0);
    run_mdu("mtlo", 4'd15, 32'hCAFEF00D, 32'd0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(10, 15));
      a = $urandom; b = $urandom;
      if (i % 6 == 1) b = 32'd0;
      if (i % 6 == 3) b = 32'hFFFFFFFF;
      run_mdu($sformatf("rnd_mdu%0d_op%0d", i, rop), rop, a, b, 1'b0);
    end

    // reset in 4th busy cycle of a divide, then multu immediately after
    run_mdu("pre_abort_mthi", 4'd14, 32'hAAAA5555, 32'd0, 1'b0);
    alu_op = 4'd12; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 4) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    chk("abort_cycles", 32'(n), 32'd4);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    run_mdu("post_abort_multu", 4'd11, 32'hFFFFFFFD, 32'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
